// File: rtl/mips_instr_encoder.sv
// Encodes MIPS instruction requests into 32-bit words and streams them into
// instruction memory at consecutive word addresses through a small FIFO.

package AluCtrlSig_pkg;

  typedef enum logic [5:0] {
    ADD_op = 6'h00,
    JMP    = 6'h02,
    BEQ    = 6'h04,
    BNE    = 6'h05,
    ADDI   = 6'h08,
    LW     = 6'h23,
    SW     = 6'h2B
  } opcode_t;

  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    ADD = 4'd2,
    SUB = 4'd6,
    SLT = 4'd7,
    NOR = 4'd12,
    XOR = 4'd13
  } AluOp_t;

endpackage

module mips_instr_encoder
  import AluCtrlSig_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [3:0]        req_alu,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              done,
  output logic              err_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               legal;
  logic [5:0]         funct;
  logic [31:0]        word;

  // Instruction word encoder; flags opcodes and ALU ops with no encoding.
  always_comb begin
    funct = 6'h00;
    legal = 1'b1;
    word  = 32'h0;
    case (req_op)
      ADD_op: begin
        case (req_alu)
          ADD:     funct = 6'h20;
          SUB:     funct = 6'h22;
          AND:     funct = 6'h24;
          OR:      funct = 6'h25;
          XOR:     funct = 6'h26;
          NOR:     funct = 6'h27;
          SLT:     funct = 6'h2A;
          default: legal = 1'b0;
        endcase
        word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, funct};
      end
      LW, SW, ADDI, BEQ, BNE: word = {req_op, req_rs, req_rt, req_imm};
      JMP:                    word = {req_op, req_target};
      default:                legal = 1'b0;
    endcase
  end

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == CNT_W'(0));
  assign req_ready  = ((state == S_IDLE) || (state == S_RUN)) && !full;
  assign accept     = req_valid && req_ready;
  assign push       = accept && legal;
  assign pop        = !empty && imem_ready;
  assign imem_we    = !empty;
  assign imem_wdata = empty ? 32'h0 : mem[rd_ptr];
  assign done       = (state == S_DONE);

  // FIFO storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Control FSM, FIFO pointers, write address and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      imem_addr   <= ADDR_W'(BASE_ADDR);
      wr_count    <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        imem_addr <= imem_addr + ADDR_W'(1);
        wr_count  <= wr_count + WC_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (accept && !legal) begin
        err_illegal <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= req_last ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (accept && req_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // No pushes happen here, so a pop of the only entry empties the FIFO.
          if (empty || (pop && (count == CNT_W'(1)))) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          imem_addr <= ADDR_W'(BASE_ADDR);
          wr_count  <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: a default instance plus a
// narrow-address instance (ADDR_W=2, BASE_ADDR=3) driven by the same stimulus.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
  import AluCtrlSig_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [5:0]  req_op;
  logic [3:0]  req_alu;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        req_last;
  logic        imem_ready;

  logic        req_ready, imem_we, done, err_illegal;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  wr_count;

  logic        w_req_ready, w_imem_we, w_done, w_err_illegal;
  logic [1:0]  w_imem_addr;
  logic [31:0] w_imem_wdata;
  logic [2:0]  w_wr_count;

  always #5 clk = ~clk;

  mips_instr_encoder u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_alu(req_alu), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target),
    .req_last(req_last), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .wr_count(wr_count),
    .done(done), .err_illegal(err_illegal)
  );

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_op(req_op), .req_alu(req_alu), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target),
    .req_last(req_last), .imem_we(w_imem_we), .imem_ready(imem_ready),
    .imem_addr(w_imem_addr), .imem_wdata(w_imem_wdata), .wr_count(w_wr_count),
    .done(w_done), .err_illegal(w_err_illegal)
  );

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  req_t        stim[$];
  logic [31:0] exp_data[$];
  int          exp_illegal;
  int          obs_addr[$];
  int          obs_waddr[$];
  logic [31:0] obs_data[$];
  int          done_cnt, wc_done, wwc_done, unstable, diverge;
  int          first_acc, first_we, stall_acc, timeout;
  logic        stall_rdy;

  function automatic req_t mk(input logic [5:0] op, input logic [3:0] alu,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic last);
    req_t r;
    r.op = op; r.alu = alu; r.rs = rs; r.rt = rt; r.rd = rd;
    r.imm = imm; r.tgt = tgt; r.last = last;
    return r;
  endfunction

  // Reference encoding: {legal, word}.
  function automatic logic [32:0] ref_encode(input req_t r);
    logic [5:0] f;
    if (r.op == 6'h00) begin
      case (r.alu)
        ADD:     f = 6'h20;
        SUB:     f = 6'h22;
        AND:     f = 6'h24;
        OR:      f = 6'h25;
        XOR:     f = 6'h26;
        NOR:     f = 6'h27;
        SLT:     f = 6'h2A;
        default: return 33'h0;
      endcase
      return {1'b1, 6'h00, r.rs, r.rt, r.rd, 5'h00, f};
    end
    if (r.op inside {6'h23, 6'h2B, 6'h08, 6'h04, 6'h05})
      return {1'b1, r.op, r.rs, r.rt, r.imm};
    if (r.op == 6'h02)
      return {1'b1, r.op, r.tgt};
    return 33'h0;
  endfunction

  function automatic void exp_build();
    logic [32:0] e;
    exp_data.delete();
    exp_illegal = 0;
    foreach (stim[i]) begin
      e = ref_encode(stim[i]);
      if (e[32]) exp_data.push_back(e[31:0]);
      else       exp_illegal++;
    end
  endfunction

  function automatic req_t rand_req(input logic last);
    req_t r;
    logic [3:0] alus[7] = '{ADD, SUB, AND, OR, XOR, NOR, SLT};
    logic [5:0] iops[5] = '{6'h23, 6'h2B, 6'h08, 6'h04, 6'h05};
    int k = $urandom_range(0, 19);
    r = mk(6'h00, alus[$urandom_range(0, 6)], 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), 26'($urandom), last);
    if (k == 8)       r.alu = 4'($urandom);
    else if (k >= 9 && k < 16) r.op = iops[$urandom_range(0, 4)];
    else if (k >= 16 && k < 18) r.op = 6'h02;
    else if (k >= 18) r.op = 6'($urandom);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives stim[] as one program load and records what reaches memory.
  task automatic run_load(input int stall, input int pct, input int budget);
    int   idx = 0;
    int   cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] pdata = '0;
    logic [7:0]  paddr = '0;
    obs_addr.delete(); obs_waddr.delete(); obs_data.delete();
    done_cnt = 0; wc_done = -1; wwc_done = -1; unstable = 0; diverge = 0;
    first_acc = -1; first_we = -1; stall_acc = -1; stall_rdy = 1'bx; timeout = 0;
    forever begin
      if (idx >= stim.size() && done_cnt > 0 && !done) break;
      if (cyc > budget) begin timeout = 1; break; end
      if (idx < stim.size()) begin
        req_valid = 1'b1; req_op = stim[idx].op; req_alu = stim[idx].alu;
        req_rs = stim[idx].rs; req_rt = stim[idx].rt; req_rd = stim[idx].rd;
        req_imm = stim[idx].imm; req_target = stim[idx].tgt; req_last = stim[idx].last;
      end else begin
        req_valid = 1'b0;
      end
      imem_ready = (cyc < stall) ? 1'b0 : ($urandom_range(0, 99) < pct);
      if (prev_stall && (imem_we !== 1'b1 || imem_wdata !== pdata || imem_addr !== paddr))
        unstable++;
      if (w_req_ready !== req_ready || w_imem_we !== imem_we || w_imem_wdata !== imem_wdata ||
          w_done !== done || w_err_illegal !== err_illegal)
        diverge++;
      if (cyc == stall) begin stall_acc = idx; stall_rdy = req_ready; end
      if (req_valid && req_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (imem_we && first_we < 0) first_we = cyc;
      if (imem_we && imem_ready) begin
        obs_addr.push_back(int'(imem_addr));
        obs_waddr.push_back(int'(w_imem_addr));
        obs_data.push_back(imem_wdata);
      end
      prev_stall = imem_we && !imem_ready;
      pdata = imem_wdata;
      paddr = imem_addr;
      if (done) begin
        done_cnt++;
        wc_done = int'(wr_count);
        wwc_done = int'(w_wr_count);
      end
      cyc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; imem_ready = 1'b0; req_op = '0; req_alu = '0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0; req_last = 1'b0;
    do_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we got %b want 0", imem_we); end
    n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    n_checks++; if (w_imem_addr !== 2'd3) begin n_fail++; $display("FAIL reset_wrap_addr got %0d want 3", w_imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    n_checks++; if (wr_count !== 9'd0 || done !== 1'b0 || err_illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_misc got wc=%0d done=%b err=%b want 0/0/0", wr_count, done, err_illegal); end
  endtask

  task automatic test_encoding();
    logic [31:0] golden[4] = '{32'h01095020, 32'h8C480004, 32'h1109FFFF, 32'h08000010};
    stim.delete();
    stim.push_back(mk(6'h00, ADD, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b0));
    stim.push_back(mk(6'h23, 4'h0, 5'd2, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0));
    stim.push_back(mk(6'h04, 4'h0, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0, 1'b0));
    stim.push_back(mk(6'h02, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1));
    run_load(0, 100, 100);
    n_checks++; if (timeout != 0 || obs_data.size() != 4) begin
      n_fail++; $display("FAIL enc_count got %0d writes (timeout=%0d) want 4", obs_data.size(), timeout); end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_checks++; if (obs_data[i] !== golden[i] || obs_addr[i] != i) begin
        n_fail++; $display("FAIL enc_word%0d got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], golden[i], i); end
    end
    n_checks++; if (first_we - first_acc != 1) begin
      n_fail++; $display("FAIL enc_latency got %0d cycles want 1", first_we - first_acc); end
    n_checks++; if (done_cnt != 1 || wc_done != 4) begin
      n_fail++; $display("FAIL enc_done got pulses=%0d wc=%0d want 1/4", done_cnt, wc_done); end
    n_checks++; if (imem_addr !== 8'd0 || wr_count !== 9'd0) begin
      n_fail++; $display("FAIL enc_reload got addr=%0d wc=%0d want 0/0", imem_addr, wr_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    req_valid = 1'b1; req_op = 6'h3F; req_alu = 4'h0; req_last = 1'b0; imem_ready = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (err_illegal !== 1'b1 || imem_we !== 1'b0) begin
      n_fail++; $display("FAIL ill_op got err=%b we=%b want 1/0", err_illegal, imem_we); end
    stim.delete();
    stim.push_back(mk(6'h00, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1));
    run_load(0, 100, 50);
    n_checks++; if (obs_data.size() != 0 || done_cnt != 1 || timeout != 0) begin
      n_fail++; $display("FAIL ill_alu got writes=%0d done=%0d timeout=%0d want 0/1/0", obs_data.size(), done_cnt, timeout); end
    stim.delete();
    stim.push_back(mk(6'h08, 4'h0, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 1'b0));
    stim.push_back(mk(6'h00, OR, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1));
    run_load(0, 100, 50);
    n_checks++; if (obs_data.size() != 2 || obs_data[0] !== 32'h20221234 || obs_data[1] !== 32'h00853025) begin
      n_fail++; $display("FAIL ill_follow got %0d writes first=%h want 2 writes 20221234,00853025", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'h0); end
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b want 1", err_illegal); end
  endtask

  task automatic test_backpressure();
    do_reset();
    stim.delete();
    for (int i = 0; i < 5; i++)
      stim.push_back(mk(6'h08, 4'h0, 5'(i), 5'(i + 1), 5'd0, 16'(16'h100 + i), 26'h0, i == 4));
    exp_build();
    run_load(8, 100, 100);
    n_checks++; if (stall_acc != 4 || stall_rdy !== 1'b0) begin
      n_fail++; $display("FAIL bp_full got accepts=%0d ready=%b want 4/0", stall_acc, stall_rdy); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    n_checks++; if (obs_data.size() != 5 || done_cnt != 1 || timeout != 0) begin
      n_fail++; $display("FAIL bp_count got writes=%0d done=%0d want 5/1", obs_data.size(), done_cnt); end
    for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
      n_checks++; if (obs_data[i] !== exp_data[i] || obs_addr[i] != i) begin
        n_fail++; $display("FAIL bp_word%0d got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], i); end
    end
  endtask

  task automatic test_wrap();
    int want[3] = '{3, 0, 1};
    do_reset();
    stim.delete();
    for (int i = 0; i < 3; i++)
      stim.push_back(mk(6'h2B, 4'h0, 5'd3, 5'd4, 5'd0, 16'(i * 4), 26'h0, i == 2));
    run_load(0, 70, 100);
    n_checks++; if (obs_waddr.size() != 3 || wwc_done != 3 || done_cnt != 1 || diverge != 0) begin
      n_fail++; $display("FAIL wrap_count got writes=%0d wc=%0d done=%0d div=%0d want 3/3/1/0", obs_waddr.size(), wwc_done, done_cnt, diverge); end
    for (int i = 0; i < 3 && i < obs_waddr.size(); i++) begin
      n_checks++; if (obs_waddr[i] != want[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d got %0d want %0d", i, obs_waddr[i], want[i]); end
    end
    stim.delete();
    stim.push_back(mk(6'h02, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3, 1'b0));
    stim.push_back(mk(6'h02, 4'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 1'b1));
    run_load(0, 100, 50);
    n_checks++; if (obs_waddr.size() != 2 || obs_waddr[0] != 3 || obs_addr[0] != 0) begin
      n_fail++; $display("FAIL wrap_reload got %0d writes first wrap addr %0d want 2 writes at 3", obs_waddr.size(), obs_waddr.size() > 0 ? obs_waddr[0] : -1); end
  endtask

  task automatic test_reset_mid_load();
    int writes = 0;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_op = 6'h08; req_rs = 5'd1; req_rt = 5'd2; req_imm = 16'(i); req_last = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL mid_queued got we=%b want 1", imem_we); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'h0 ||
                    wr_count !== 9'd0 || done !== 1'b0 || err_illegal !== 1'b0 || w_imem_addr !== 2'd3) begin
      n_fail++; $display("FAIL mid_reset got rdy=%b we=%b addr=%0d wd=%h wc=%0d done=%b err=%b want 1/0/0/0/0/0/0",
                         req_ready, imem_we, imem_addr, imem_wdata, wr_count, done, err_illegal); end
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (imem_we) writes++;
      @(negedge clk);
    end
    n_checks++; if (writes != 0) begin n_fail++; $display("FAIL mid_nowrites got %0d want 0", writes); end
    stim.delete();
    stim.push_back(mk(6'h05, 4'h0, 5'd7, 5'd8, 5'd0, 16'h0002, 26'h0, 1'b0));
    stim.push_back(mk(6'h00, SLT, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 1'b1));
    run_load(0, 100, 50);
    n_checks++; if (obs_data.size() != 2 || obs_addr[0] != 0 || obs_waddr[0] != 3 || obs_data[0] !== 32'h14E80002) begin
      n_fail++; $display("FAIL mid_next got %0d writes first %h@%0d want 2 writes 14e80002@0", obs_data.size(),
                         obs_data.size() > 0 ? obs_data[0] : 32'h0, obs_addr.size() > 0 ? obs_addr[0] : -1); end
  endtask

  task automatic test_random();
    logic err_exp = 1'b0;
    int   n;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 6);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(rand_req(i == n - 1));
      exp_build();
      if (exp_illegal > 0) err_exp = 1'b1;
      run_load($urandom_range(0, 3), $urandom_range(30, 100), 300);
      n_checks++; if (timeout != 0 || obs_data.size() != exp_data.size() || done_cnt != 1) begin
        n_fail++; $display("FAIL rnd%0d_count got writes=%0d done=%0d timeout=%0d want %0d/1/0", p, obs_data.size(), done_cnt, timeout, exp_data.size()); end
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        n_checks++; if (obs_data[i] !== exp_data[i] || obs_addr[i] != i || obs_waddr[i] != ((3 + i) % 4)) begin
          n_fail++; $display("FAIL rnd%0d_word%0d got %h@%0d/%0d want %h@%0d/%0d", p, i, obs_data[i], obs_addr[i], obs_waddr[i],
                             exp_data[i], i, (3 + i) % 4); end
      end
      n_checks++; if (wc_done != exp_data.size() || wwc_done != exp_data.size() || unstable != 0 || diverge != 0) begin
        n_fail++; $display("FAIL rnd%0d_status got wc=%0d wwc=%0d unstable=%0d div=%0d want %0d/%0d/0/0", p, wc_done, wwc_done,
                           unstable, diverge, exp_data.size(), exp_data.size()); end
      n_checks++; if (err_illegal !== err_exp) begin
        n_fail++; $display("FAIL rnd%0d_err got %b want %b", p, err_illegal, err_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_encoding();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Encodes MIPS instruction requests into 32-bit words and writes them into instruction memory at consecutive word addresses. Each request carries an opcode, ALU operation and register fields using the `AluCtrlSig_pkg` encodings. The block is the encoder end of the opcode/ALU-op encoding that the CPU control path decodes. The test harness uses it to load programs into the instruction memory before and between CPU runs; a small FIFO between the request side and the memory side absorbs memory backpressure.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address of every program load.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_op`  in  6  opcode in `opcode_t` encoding (LW, SW, ADDI, BEQ, BNE, ADD_op = R-type, JMP).
- `req_alu`  in  4  `AluOp_t` value; used only when `req_op` = ADD_op.
- `req_rs`, `req_rt`, `req_rd`  in  5 each  register numbers.
- `req_imm`  in  16  I-type immediate or offset.
- `req_target`  in  26  J-type target.
- `req_last`  in  1  marks the final instruction of the program.
- `imem_we`  out  1  write request to instruction memory.
- `imem_ready`  in  1  memory accepts the write when `imem_we && imem_ready`.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  encoded instruction.
- `wr_count`  out  ADDR_W+1  words written since the last load started.
- `done`  out  1  one-cycle pulse when the whole program has been written.
- `err_illegal`  out  1  sticky flag; set by an illegal opcode or ALU op.

## Operation
- **R-type** (`req_op` = 6'b000000): the word is {6'b0, rs, rt, rd, 5'b0, funct}. The funct field comes from `req_alu`:
  - ADD → 0x20, SUB → 0x22, AND → 0x24, OR → 0x25
  - XOR → 0x26, NOR → 0x27, SLT → 0x2A
  - any other `req_alu` value is illegal.
- **I-type** (LW 0x23, SW 0x2B, ADDI 0x08, BEQ 0x04, BNE 0x05): the word is {op, rs, rt, imm}. `req_rd` is ignored.
- **J-type** (JMP 0x02): the word is {op, target}.
- **Other opcodes** are illegal.
- **Illegal requests** are still handshaken (consumed). They are not pushed to the FIFO, and they set `err_illegal`. A `req_last` on an illegal request is still honoured.
- **FIFO:** DEPTH × 32 bits. The head drives `imem_wdata`, and `imem_we` = FIFO not empty.
- **Address:** `imem_addr` increments by 1 on every accepted write. It wraps modulo 2^ADDR_W with no error. `wr_count` increments on every accepted write.
- **State machine:**
  - **IDLE:** `req_ready` = !full. The first accepted request moves to RUN, or to DRAIN if it carries `req_last`.
  - **RUN:** `req_ready` = !full. An accepted `req_last` moves to DRAIN.
  - **DRAIN:** `req_ready` = 0. Moves to DONE once the FIFO is empty, either already empty or emptied by the final write completing.
  - **DONE:** `done` = 1 for one cycle. Reloads `imem_addr` to BASE_ADDR and clears `wr_count`, then goes to IDLE. `req_ready` = 0.
- Push and pop in the same cycle leave the occupancy unchanged. When the FIFO is full, `req_ready` = 0, even if a pop happens that same cycle.
- `err_illegal` is cleared only by `rst`.

## Timing
- **Reset values:**
  - `req_ready` = 1, `imem_we` = 0, `imem_addr` = BASE_ADDR
  - `imem_wdata` = 0, `wr_count` = 0, `done` = 0, `err_illegal` = 0
  - state = IDLE, FIFO empty.
- `rst` mid-load discards all FIFO contents and any partial program.
- **Latency:** a request accepted at edge N into an empty FIFO gives `imem_we` = 1 with its word in cycle N+1.
- **Throughput:** one word per cycle while `imem_ready` = 1.
- `imem_addr`, `imem_wdata` and `imem_we` stay stable while `imem_we && !imem_ready`.
- `done` rises in the cycle after the final write is accepted.
- `err_illegal` rises in the cycle after the illegal handshake.

## Test plan
- **Encoding:** ADD t2,t0,t1 (rs=8, rt=9, rd=10, alu=ADD) → `imem_wdata` = 0x01095020 at addr 0. LW t0,4(v0) (rs=2, rt=8, imm=4) → 0x8C480004 at addr 1. BEQ t0,t1,-1 → 0x1109FFFF. JMP target=0x10 → 0x08000010.
- **Illegal input:** `req_op` = 6'b111111, then R-type with `req_alu` = 4'd3 → both handshaken, no `imem_we`, `err_illegal` = 1 and stays 1 through a following legal program.
- **Backpressure:** `imem_ready` = 0 while 5 requests are offered → `req_ready` drops after 4 accepts. Then `imem_ready` = 1 → 5 writes, addrs 0–4, in order, with stable data while stalled.
- **Wrap and reload:** ADDR_W = 2, BASE_ADDR = 3, 3-instruction program with `req_last` on the third → addrs 3, 0, 1, `wr_count` = 3, `done` pulses once. The next load starts again at addr 3.
- **Reset mid-load:** 2 words queued with `imem_ready` = 0, then `rst` → no writes afterward, all outputs at reset values, and the next program starts at BASE_ADDR.
